vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 77 +++++++
 rtl/vga_timing_gen_sync_delay.sv | 58 +++++
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing constants and helpers.
//   - 800x600 @ 60 Hz (40 MHz pixel clock, positive syncs): default raster
//   - 640x480 @ 60 Hz (25.175 MHz pixel clock, negative syncs): alternate set
//   - seg_t / segment_of(): classify a counter position into line/frame
//     segments (active, front porch, sync, back porch)
//   - sync_bundle_t: the three raster flags carried through the delay line
// ---------------------------------------------------------------------------
package vga_pkg;

  // 800x600 @ 60 Hz
  localparam int   SVGA_H_ACTIVE = 800;
  localparam int   SVGA_H_FP     = 40;
  localparam int   SVGA_H_SYNC   = 128;
  localparam int   SVGA_H_BP     = 88;
  localparam int   SVGA_V_ACTIVE = 600;
  localparam int   SVGA_V_FP     = 1;
  localparam int   SVGA_V_SYNC   = 4;
  localparam int   SVGA_V_BP     = 23;
  localparam logic SVGA_HS_POL   = 1'b1;
  localparam logic SVGA_VS_POL   = 1'b1;

  // 640x480 @ 60 Hz
  localparam int   VGA_H_ACTIVE  = 640;
  localparam int   VGA_H_FP      = 16;
  localparam int   VGA_H_SYNC    = 96;
  localparam int   VGA_H_BP      = 48;
  localparam int   VGA_V_ACTIVE  = 480;
  localparam int   VGA_V_FP      = 10;
  localparam int   VGA_V_SYNC    = 2;
  localparam int   VGA_V_BP      = 33;
  localparam logic VGA_HS_POL    = 1'b0;
  localparam logic VGA_VS_POL    = 1'b0;

  // Latency of the pixel path in the display stage; the sync/vidon delay
  // line defaults to this so syncs stay aligned with the pixel data.
  localparam int   DISPLAY_PIPE_LATENCY = 2;
  localparam int   MAX_PIPE_DLY         = 7;

  typedef enum logic [1:0] {
    SEG_ACTIVE,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } seg_t;

  // Packed so it maps directly onto a 3-bit delay-line word.
  typedef struct packed {
    logic vidon;
    logic hsync;
    logic vsync;
  } sync_bundle_t;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Segment order along a line (or frame): active, front porch, sync,
  // back porch.
  function automatic seg_t segment_of(input int pos, input int active,
                                      input int fp, input int sync);
    seg_t seg;
    if (pos < active) begin
      seg = SEG_ACTIVE;
    end else if (pos < active + fp) begin
      seg = SEG_FRONT;
    end else if (pos < active + fp + sync) begin
      seg = SEG_SYNC;
    end else begin
      seg = SEG_BACK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay
// Fixed-length delay line of WIDTH-bit words, DEPTH stages. Shifts on every
// rising clock edge (no enable). All stages load INIT while i_rst_n is low.
// DEPTH = 0 is a pass-through that still shows INIT during reset, so the
// outputs have the same reset behaviour at every depth.
//   i_clk    in   1      clock
//   i_rst_n  in   1      asynchronous active-low reset
//   i_d      in   WIDTH  word entering the line
//   o_q      out  WIDTH  word delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sync_delay #(
  parameter int               DEPTH = 2,
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_passthru
    logic w_unusedClk;
    assign w_unusedClk = i_clk;
    assign o_q = i_rst_n ? i_d : INIT;

  end else if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] r_stage;

    // Single register stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_stage <= INIT;
      end else begin
        r_stage <= i_d;
      end
    end

    assign o_q = r_stage;

  end else begin : g_multi
    // Stage 0 occupies the low WIDTH bits; the oldest word sits at the top.
    logic [DEPTH*WIDTH-1:0] r_shift;

    // Shift register: new word in at the bottom, oldest word out of the top.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_shift <= {DEPTH{INIT}};
      end else begin
        r_shift <= {r_shift[(DEPTH-1)*WIDTH-1:0], i_d};
      end
    end

    assign o_q = r_shift[DEPTH*WIDTH-1 -: WIDTH];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator: pixel/line counters, sync and active-video flags,
// start-of-frame / end-of-line pulses and a completed-frame counter.
// hsync/vsync/vidon pass through a PIPE_DLY-stage delay line so they line up
// with a pipelined pixel path; hc, vc, sof and eol are undelayed.
//   clk        in   1      pixel clock, rising edge
//   clr_n      in   1      asynchronous active-low reset
//   en         in   1      count enable (low freezes the raster)
//   resync     in   1      synchronous restart of the raster at (0,0)
//   hc         out  CNT_W  current pixel column
//   vc         out  CNT_W  current line
//   hsync      out  1      horizontal sync, delayed PIPE_DLY cycles
//   vsync      out  1      vertical sync, delayed PIPE_DLY cycles
//   vidon      out  1      active-video flag, delayed PIPE_DLY cycles
//   sof        out  1      start-of-frame pulse
//   eol        out  1      end-of-line pulse
//   frame_cnt  out  FC_W   completed-frame count (wraps)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FP     = SVGA_H_FP,
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BP     = SVGA_H_BP,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FP     = SVGA_V_FP,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BP     = SVGA_V_BP,
  parameter logic HS_POL   = SVGA_HS_POL,
  parameter logic VS_POL   = SVGA_VS_POL,
  parameter int   CNT_W    = 11,
  parameter int   PIPE_DLY = DISPLAY_PIPE_LATENCY,
  parameter int   FC_W     = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             resync,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             hsync,
  output logic             vsync,
  output logic             vidon,
  output logic             sof,
  output logic             eol,
  output logic [FC_W-1:0]  frame_cnt
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Idle level of every delay stage: video off, both syncs inactive.
  localparam sync_bundle_t IDLE_BUNDLE = '{vidon: 1'b0,
                                           hsync: ~HS_POL,
                                           vsync: ~VS_POL};

  // Reject parameter sets the counters or the delay line cannot represent.
  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d does not fit in CNT_W=%0d bits",
           H_TOTAL, CNT_W);
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d does not fit in CNT_W=%0d bits",
           V_TOTAL, CNT_W);
  end
  if (PIPE_DLY < 0 || PIPE_DLY > MAX_PIPE_DLY) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY %0d outside 0..%0d",
           PIPE_DLY, MAX_PIPE_DLY);
  end

  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_vc;
  logic [FC_W-1:0]  r_frameCnt;
  logic             w_lineEnd;
  logic             w_frameEnd;
  seg_t             w_hSeg;
  seg_t             w_vSeg;
  sync_bundle_t     w_raw;
  sync_bundle_t     w_dly;

  assign w_lineEnd  = (r_hc == H_LAST);
  assign w_frameEnd = w_lineEnd && (r_vc == V_LAST);

  // Raster counters. resync wins over en so a frozen raster can still be
  // re-aligned; it restarts the position without counting a frame.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hc       <= '0;
      r_vc       <= '0;
      r_frameCnt <= '0;
    end else if (resync) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (en) begin
      if (w_lineEnd) begin
        r_hc <= '0;
        if (w_frameEnd) begin
          r_vc       <= '0;
          r_frameCnt <= r_frameCnt + 1'b1;
        end else begin
          r_vc <= r_vc + 1'b1;
        end
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

  // Undelayed sync/video flags decoded from the registered position.
  always_comb begin
    w_hSeg = segment_of(32'(r_hc), H_ACTIVE, H_FP, H_SYNC);
    w_vSeg = segment_of(32'(r_vc), V_ACTIVE, V_FP, V_SYNC);

    w_raw       = IDLE_BUNDLE;
    w_raw.vidon = (w_hSeg == SEG_ACTIVE) && (w_vSeg == SEG_ACTIVE);
    w_raw.hsync = (w_hSeg == SEG_SYNC) ? HS_POL : ~HS_POL;
    w_raw.vsync = (w_vSeg == SEG_SYNC) ? VS_POL : ~VS_POL;
  end

  sync_delay #(
    .DEPTH (PIPE_DLY),
    .WIDTH (3),
    .INIT  (IDLE_BUNDLE)
  ) u_sync_delay (
    .i_clk   (clk),
    .i_rst_n (clr_n),
    .i_d     (w_raw),
    .o_q     (w_dly)
  );

  assign hsync = w_dly.hsync;
  assign vsync = w_dly.vsync;
  assign vidon = w_dly.vidon;

  // Pulses are qualified with en so a frozen raster never repeats them, and
  // with clr_n so they are low for the whole of reset.
  assign sof = clr_n && en && (r_hc == '0) && (r_vc == '0);
  assign eol = clr_n && en && w_lineEnd;

  assign hc        = r_hc;
  assign vc        = r_vc;
  assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances on a small 16x8 raster (H 8/2/3/3, V 4/1/2/1) share the
// same stimulus:
//   A: positive syncs, PIPE_DLY=2, FC_W=2
//   B: negative syncs, PIPE_DLY=0
//   C: positive syncs, PIPE_DLY=7
// hsync is active for hc 10..12, vsync for vc 5..6, video for hc<8 && vc<4;
// a frame is 128 cycles.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk    = 1'b0;
  logic clr_n  = 1'b0;
  logic en     = 1'b0;
  logic resync = 1'b0;

  logic [10:0] hcA, vcA, hcB, vcB, hcC, vcC;
  logic        hsA, vsA, vidA, sofA, eolA;
  logic        hsB, vsB, vidB, sofB, eolB;
  logic        hsC, vsC, vidC, sofC, eolC;
  logic [1:0]  fcA, fcB, fcC;

  int checkCount = 0;
  int failCount  = 0;
  int sofCount;
  int eolCount;
  int fcExp [5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .PIPE_DLY(2), .FC_W(2)
  ) dutA (
    .clk(clk), .clr_n(clr_n), .en(en), .resync(resync),
    .hc(hcA), .vc(vcA), .hsync(hsA), .vsync(vsA), .vidon(vidA),
    .sof(sofA), .eol(eolA), .frame_cnt(fcA)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11), .PIPE_DLY(0), .FC_W(2)
  ) dutB (
    .clk(clk), .clr_n(clr_n), .en(en), .resync(resync),
    .hc(hcB), .vc(vcB), .hsync(hsB), .vsync(vsB), .vidon(vidB),
    .sof(sofB), .eol(eolB), .frame_cnt(fcB)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .PIPE_DLY(7), .FC_W(2)
  ) dutC (
    .clk(clk), .clr_n(clr_n), .en(en), .resync(resync),
    .hc(hcC), .vc(vcC), .hsync(hsC), .vsync(vsC), .vidon(vidC),
    .sof(sofC), .eol(eolC), .frame_cnt(fcC)
  );

  // Expected undelayed flags for raster position p (cycles since (0,0)).
  function automatic logic rawH(input int p);
    int h;
    h = p % 16;
    return (h >= 10) && (h <= 12);
  endfunction

  function automatic logic rawV(input int p);
    int v;
    v = (p % 128) / 16;
    return (v >= 5) && (v <= 6);
  endfunction

  function automatic logic rawVid(input int p);
    return ((p % 16) < 8) && (((p % 128) / 16) < 4);
  endfunction

  // Advance n rising edges and land 2 time units after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Upper bound on run time in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expAHs, expAVs, expAVid, expCHs;

    // Reset state, held across a couple of edges.
    clr_n = 1'b0; en = 1'b0; resync = 1'b0;
    applyStimulus(2);
    checkOutput("rst hcA",   32'(hcA),  32'd0);
    checkOutput("rst vcA",   32'(vcA),  32'd0);
    checkOutput("rst fcA",   32'(fcA),  32'd0);
    checkOutput("rst sofA",  32'(sofA), 32'd0);
    checkOutput("rst eolA",  32'(eolA), 32'd0);
    checkOutput("rst hsA",   32'(hsA),  32'd0);
    checkOutput("rst vsA",   32'(vsA),  32'd0);
    checkOutput("rst vidA",  32'(vidA), 32'd0);
    checkOutput("rst hsB",   32'(hsB),  32'd1);
    checkOutput("rst vsB",   32'(vsB),  32'd1);
    checkOutput("rst vidB",  32'(vidB), 32'd0);
    checkOutput("rst hsC",   32'(hsC),  32'd0);
    checkOutput("rst vidC",  32'(vidC), 32'd0);

    // Release and run two full frames.
    clr_n = 1'b1; en = 1'b1;
    #1;
    sofCount = 0; eolCount = 0;
    for (int t = 0; t < 256; t++) begin
      if (sofA) sofCount++;
      if (eolA) eolCount++;
      if (t == 0) checkOutput("first sofA", 32'(sofA), 32'd1);
      if (t < 16) begin
        checkOutput($sformatf("hcA t=%0d", t), 32'(hcA), 32'(t));
        checkOutput($sformatf("vcA t=%0d", t), 32'(vcA), 32'd0);
      end
      expAHs  = (t >= 2) ? rawH(t - 2)   : 1'b0;
      expAVs  = (t >= 2) ? rawV(t - 2)   : 1'b0;
      expAVid = (t >= 2) ? rawVid(t - 2) : 1'b0;
      expCHs  = (t >= 7) ? rawH(t - 7)   : 1'b0;
      checkOutput($sformatf("hsA t=%0d", t),  32'(hsA),  32'(expAHs));
      checkOutput($sformatf("vsA t=%0d", t),  32'(vsA),  32'(expAVs));
      checkOutput($sformatf("vidA t=%0d", t), 32'(vidA), 32'(expAVid));
      checkOutput($sformatf("hsB t=%0d", t),  32'(hsB),  32'(!rawH(t)));
      checkOutput($sformatf("vsB t=%0d", t),  32'(vsB),  32'(!rawV(t)));
      checkOutput($sformatf("vidB t=%0d", t), 32'(vidB), 32'(rawVid(t)));
      checkOutput($sformatf("hsC t=%0d", t),  32'(hsC),  32'(expCHs));
      if (t == 15) checkOutput("eolA t=15", 32'(eolA), 32'd1);
      if (t == 16) begin
        checkOutput("hcA t=16", 32'(hcA), 32'd0);
        checkOutput("vcA t=16", 32'(vcA), 32'd1);
      end
      if (t == 127) begin
        checkOutput("hcA t=127", 32'(hcA), 32'd15);
        checkOutput("vcA t=127", 32'(vcA), 32'd7);
        checkOutput("fcA t=127", 32'(fcA), 32'd0);
        checkOutput("eolA t=127", 32'(eolA), 32'd1);
      end
      if (t == 128) begin
        checkOutput("hcA t=128", 32'(hcA), 32'd0);
        checkOutput("vcA t=128", 32'(vcA), 32'd0);
        checkOutput("sofA t=128", 32'(sofA), 32'd1);
        checkOutput("fcA t=128", 32'(fcA), 32'd1);
      end
      applyStimulus(1);
    end
    checkOutput("sof count 2 frames", 32'(sofCount), 32'd2);
    checkOutput("eol count 2 frames", 32'(eolCount), 32'd16);
    checkOutput("fcA after 2 frames", 32'(fcA), 32'd2);

    // Freeze at hc=5, vc=3 for 20 cycles.
    applyStimulus(53);
    checkOutput("pre-freeze hcA", 32'(hcA), 32'd5);
    checkOutput("pre-freeze vcA", 32'(vcA), 32'd3);
    en = 1'b0;
    #1;
    sofCount = 0; eolCount = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      if (sofA) sofCount++;
      if (eolA) eolCount++;
      checkOutput($sformatf("frozen hcA k=%0d", k), 32'(hcA), 32'd5);
      checkOutput($sformatf("frozen vcA k=%0d", k), 32'(vcA), 32'd3);
    end
    checkOutput("frozen sof count", 32'(sofCount), 32'd0);
    checkOutput("frozen eol count", 32'(eolCount), 32'd0);
    checkOutput("frozen vidA", 32'(vidA), 32'd1);
    checkOutput("frozen vidC", 32'(vidC), 32'd1);
    checkOutput("frozen hsA",  32'(hsA),  32'd0);
    checkOutput("frozen fcA",  32'(fcA),  32'd2);
    en = 1'b1;
    applyStimulus(1);
    checkOutput("resume hcA", 32'(hcA), 32'd6);
    checkOutput("resume vcA", 32'(vcA), 32'd3);

    // Resync at hc=9, vc=6 with en low.
    applyStimulus(51);
    checkOutput("pre-resync hcA", 32'(hcA), 32'd9);
    checkOutput("pre-resync vcA", 32'(vcA), 32'd6);
    en = 1'b0; resync = 1'b1;
    applyStimulus(1);
    resync = 1'b0;
    #1;
    checkOutput("resync hcA",  32'(hcA),  32'd0);
    checkOutput("resync vcA",  32'(vcA),  32'd0);
    checkOutput("resync fcA",  32'(fcA),  32'd2);
    checkOutput("resync sofA", 32'(sofA), 32'd0);
    checkOutput("resync vsA not flushed", 32'(vsA), 32'd1);
    checkOutput("resync vsB", 32'(vsB), 32'd1);
    applyStimulus(2);
    checkOutput("resync vsA drained", 32'(vsA), 32'd0);
    en = 1'b1;
    #1;
    checkOutput("resync sofA on en", 32'(sofA), 32'd1);
    applyStimulus(1);
    checkOutput("post-resync hcA",  32'(hcA),  32'd1);
    checkOutput("post-resync sofA", 32'(sofA), 32'd0);

    // Asynchronous reset in the middle of hsync.
    applyStimulus(11);
    checkOutput("mid-sync hcA",  32'(hcA),  32'd12);
    checkOutput("mid-sync hsA",  32'(hsA),  32'd1);
    checkOutput("mid-sync hsB",  32'(hsB),  32'd0);
    checkOutput("mid-sync vidC", 32'(vidC), 32'd1);
    clr_n = 1'b0;
    #1;
    checkOutput("async rst hcA",  32'(hcA),  32'd0);
    checkOutput("async rst vcA",  32'(vcA),  32'd0);
    checkOutput("async rst fcA",  32'(fcA),  32'd0);
    checkOutput("async rst sofA", 32'(sofA), 32'd0);
    checkOutput("async rst eolA", 32'(eolA), 32'd0);
    checkOutput("async rst hsA",  32'(hsA),  32'd0);
    checkOutput("async rst vidA", 32'(vidA), 32'd0);
    checkOutput("async rst hsB",  32'(hsB),  32'd1);
    checkOutput("async rst vidB", 32'(vidB), 32'd0);
    checkOutput("async rst vidC", 32'(vidC), 32'd0);
    applyStimulus(2);

    // Release and count five frames on the 2-bit frame counter.
    clr_n = 1'b1;
    #1;
    checkOutput("re-release sofA", 32'(sofA), 32'd1);
    for (int t = 0; t <= 640; t++) begin
      if (t == 6) checkOutput("vidC t=6", 32'(vidC), 32'd0);
      if (t == 7) checkOutput("vidC t=7", 32'(vidC), 32'd1);
      if (t == 127) checkOutput("fcA t=127 after rst", 32'(fcA), 32'd0);
      if ((t > 0) && (t % 128 == 0)) begin
        checkOutput($sformatf("fcA frame %0d", t / 128), 32'(fcA),
                    32'(fcExp[(t / 128) - 1]));
      end
      applyStimulus(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
